// File: rtl/tft_mcu_bus_master.sv
// Host-side initiator for a 16-bit 8080-style MCU parallel bus.
// Issues one CS/RS/WR/RD/DATA cycle per accepted request.
module tft_mcu_bus_master #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 3,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rs,
  input  logic        req_rnw,
  input  logic        req_last,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        bus_cs,
  output logic        bus_rs,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [15:0] bus_dout,
  output logic        bus_doe,
  input  logic [15:0] bus_din
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        rnw_q;
  logic        last_q;
  logic        cs_q;
  logic        rs_q;
  logic        wr_q;
  logic        rd_q;
  logic [15:0] dout_q;
  logic        doe_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;

  logic        cnt_done;

  assign cnt_done  = (cnt_q == 4'd0);
  assign req_ready = (state_q == IDLE) && !RST;
  assign busy      = (state_q != IDLE);

  assign bus_cs    = cs_q;
  assign bus_rs    = rs_q;
  assign bus_wr    = wr_q;
  assign bus_rd    = rd_q;
  assign bus_dout  = dout_q;
  assign bus_doe   = doe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rnw_q       <= 1'b0;
      last_q      <= 1'b0;
      cs_q        <= 1'b1;
      rs_q        <= 1'b1;
      wr_q        <= 1'b1;
      rd_q        <= 1'b1;
      dout_q      <= 16'h0000;
      doe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= SETUP;
            cnt_q   <= SETUP_LD;
            rnw_q   <= req_rnw;
            last_q  <= req_last;
            cs_q    <= 1'b0;
            rs_q    <= req_rs;
            doe_q   <= !req_rnw;
            if (!req_rnw) begin
              dout_q <= req_wdata;
            end
          end
        end
        SETUP: begin
          if (cnt_done) begin
            state_q <= STROBE;
            cnt_q   <= PULSE_LD;
            wr_q    <= rnw_q;
            rd_q    <= !rnw_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_done) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LD;
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
            // Read data is sampled as RD rises, valid for the first HOLD cycle.
            if (rnw_q) begin
              rsp_rdata_q <= bus_din;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_done) begin
            state_q <= IDLE;
            doe_q   <= 1'b0;
            // CS stays low between burst words so the panel sees one access.
            if (last_q) begin
              cs_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_mcu_bus_master.sv
// Directed bench for tft_mcu_bus_master: writes, reads, streaming,
// reset abort and request backpressure at default timing (2/3/2).
module tb_tft_mcu_bus_master;

  logic        clk;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_rs;
  logic        req_rnw;
  logic        req_last;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        bus_cs;
  logic        bus_rs;
  logic        bus_wr;
  logic        bus_rd;
  logic [15:0] bus_dout;
  logic        bus_doe;
  logic [15:0] bus_din;

  int checks;
  int errors;

  tft_mcu_bus_master dut (
    .clk       (clk),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_rnw   (req_rnw),
    .req_last  (req_last),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .bus_cs    (bus_cs),
    .bus_rs    (bus_rs),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_dout  (bus_dout),
    .bus_doe   (bus_doe),
    .bus_din   (bus_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] busv();
    return {bus_cs, bus_rs, bus_wr, bus_rd, bus_doe};
  endfunction

  // {cs, rs, wr, rd, doe} per cycle after the accepting edge
  logic [4:0] wexp [16];
  logic [4:0] rexp [8];
  logic [15:0] words [3];
  int fall [3];
  int nf, mism, cshigh, wrlow, rspcnt, acc, bad;
  logic prev_wr;

  initial begin
    checks = 0;
    errors = 0;
    wexp = '{5'b00111, 5'b00111, 5'b00011, 5'b00011, 5'b00011,
             5'b00111, 5'b00111, 5'b00110, 5'b01111, 5'b01111,
             5'b01011, 5'b01011, 5'b01011, 5'b01111, 5'b01111,
             5'b11110};
    rexp = '{5'b01110, 5'b01110, 5'b01100, 5'b01100, 5'b01100,
             5'b01110, 5'b01110, 5'b11110};
    words = '{16'h001F, 16'h0020, 16'h0021};
    RST = 1'b1;
    req_valid = 1'b0;
    req_rs = 1'b0;
    req_rnw = 1'b0;
    req_last = 1'b0;
    req_wdata = 16'h0000;
    bus_din = 16'h0000;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    #1;
    chk("rst_bus", 32'(busv()), 32'(5'b11110));
    chk("rst_dout", 32'(bus_dout), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);

    // Register write pair: command 0x0001 then data 0x0002
    @(negedge clk);
    req_valid = 1'b1;
    req_rs = 1'b0;
    req_rnw = 1'b0;
    req_last = 1'b0;
    req_wdata = 16'h0001;
    @(posedge clk);
    #1;
    req_rs = 1'b1;
    req_last = 1'b1;
    req_wdata = 16'h0002;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("wpair_bus_c%0d", c), 32'(busv()), 32'(wexp[c]));
      if (c >= 2 && c <= 4)
        chk("wpair_dout1", 32'(bus_dout), 32'h0001);
      if (c >= 10 && c <= 12)
        chk("wpair_dout2", 32'(bus_dout), 32'h0002);
      if (c == 1)
        chk("wpair_busy_ready", 32'({busy, req_ready}), 32'b10);
      if (c == 7) begin
        chk("wpair_idle_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
      end
    end

    // Read with bus_din driven during STROBE
    @(negedge clk);
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_rnw = 1'b1;
    req_last = 1'b1;
    req_wdata = 16'hFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rspcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) bus_din = 16'hA5C3;
      chk($sformatf("read_bus_c%0d", c), 32'(busv()), 32'(rexp[c]));
      if (rsp_valid) rspcnt++;
      if (c == 5) begin
        chk("read_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("read_rdata", 32'(rsp_rdata), 32'hA5C3);
      end
    end
    chk("read_rsp_once", 32'(rspcnt), 32'd1);
    bus_din = 16'h0000;

    // Pixel stream with req_valid held
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_rnw = 1'b0;
    req_last = 1'b0;
    req_wdata = words[0];
    @(posedge clk);
    nf = 0;
    mism = 0;
    cshigh = 0;
    prev_wr = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) req_wdata = words[1];
      if (c == 8) begin
        req_wdata = words[2];
        req_last = 1'b1;
      end
      if (c == 16) req_valid = 1'b0;
      if (prev_wr && !bus_wr && nf < 3) begin
        fall[nf] = c;
        nf++;
      end
      if (!bus_wr && nf > 0 && bus_dout !== words[nf-1]) mism++;
      if (c <= 22 && bus_cs) cshigh++;
      if (c == 23) chk("stream_cs_release", 32'(bus_cs), 32'h1);
      prev_wr = bus_wr;
    end
    chk("stream_nfalls", 32'(nf), 32'd3);
    chk("stream_first_fall", 32'(fall[0]), 32'd2);
    chk("stream_gap01", 32'(fall[1] - fall[0]), 32'd8);
    chk("stream_gap12", 32'(fall[2] - fall[1]), 32'd8);
    chk("stream_dout_mism", 32'(mism), 32'd0);
    chk("stream_cs_glitch", 32'(cshigh), 32'd0);

    // Reset during the second STROBE cycle of a read
    @(negedge clk);
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_rnw = 1'b1;
    req_last = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) bus_din = 16'h1234;
    end
    chk("rstmid_rd_low", 32'(bus_rd), 32'h0);
    RST = 1'b1;
    #1;
    chk("rstmid_ready_low", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("rstmid_bus", 32'(busv()), 32'(5'b11110));
    chk("rstmid_rsp", 32'({rsp_valid, rsp_rdata}), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    RST = 1'b0;
    bus_din = 16'h0000;
    rspcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) rspcnt++;
    end
    chk("rstmid_no_rsp", 32'(rspcnt), 32'd0);

    req_valid = 1'b1;
    req_rs = 1'b1;
    req_rnw = 1'b0;
    req_last = 1'b1;
    req_wdata = 16'h5A5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wrlow = 0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!bus_wr) begin
        wrlow++;
        if (bus_dout !== 16'h5A5A || !bus_doe || bus_cs) bad++;
      end
    end
    chk("post_rst_wrlow", 32'(wrlow), 32'd3);
    chk("post_rst_bad", 32'(bad), 32'd0);
    chk("post_rst_cs", 32'(bus_cs), 32'h1);

    // Backpressure: wdata changes while busy
    @(negedge clk);
    req_valid = 1'b1;
    req_wdata = 16'h1111;
    @(posedge clk);
    #1;
    req_wdata = 16'h2222;
    wrlow = 0;
    bad = 0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      if (c == 6) req_valid = 1'b0;
      if (c <= 6 && bus_dout !== 16'h1111) bad++;
      if (!bus_wr) wrlow++;
    end
    chk("bp_accepts_while_busy", 32'(acc), 32'd0);
    chk("bp_wrlow", 32'(wrlow), 32'd3);
    chk("bp_dout_1111", 32'(bad), 32'd0);
    chk("bp_idle", 32'({busy, bus_cs}), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tft_mcu_bus_master.md
Name: tft_mcu_bus_master

Overview:
- Host-side initiator for the 16-bit 8080-style MCU parallel bus (CS, RS, WR, RD, DATA) that the CPLD TFT controller decodes.
- Takes command/data transfer requests on a valid/ready handshake and generates bus cycles with parameterised setup, strobe and hold timing.
- Supports write and read cycles; returns read data on a response strobe.
- Sits in the host FPGA/MCU-replacement logic, or as a synthesizable bus driver in system benches, in front of the TFT/SDRAM controller.

Parameters:
- SETUP_CYC, 2, clk cycles with CS/RS/DATA valid before the strobe falls (1..15)
- PULSE_CYC, 3, clk cycles WR or RD is held low (1..15)
- HOLD_CYC, 2, clk cycles CS/RS/DATA held after the strobe rises (1..15)

Ports:
- clk  in  1  system clock
- RST  in  1  synchronous reset, active-high
- req_valid  in  1  transfer request
- req_ready  out  1  high when a request can be accepted
- req_rs  in  1  0 = command/register index, 1 = data
- req_rnw  in  1  1 = read cycle, 0 = write cycle
- req_last  in  1  release CS (drive high) after this transfer
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  16  captured read data
- busy  out  1  transfer in progress (state != IDLE)
- bus_cs  out  1  chip select, active-low
- bus_rs  out  1  register select
- bus_wr  out  1  write strobe, active-low
- bus_rd  out  1  read strobe, active-low
- bus_dout  out  16  data driven to bus
- bus_doe  out  1  data output enable; the top level tristates DATA when low
- bus_din  in  16  data sampled from bus

Behaviour:
- Reset (sync, RST=1 at a clk edge):
  - Bus outputs: bus_cs=1, bus_rs=1, bus_wr=1, bus_rd=1, bus_dout=0, bus_doe=0.
  - Response outputs: rsp_valid=0, rsp_rdata=0.
  - State goes to IDLE.
  - Reset mid-transfer aborts immediately. The in-flight transfer is dropped and no rsp_valid is issued.
- Outputs: all bus_* outputs and rsp_* are registered. req_ready = (state==IDLE) && !RST, combinational.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. A 4-bit down-counter is loaded on each state entry.
- IDLE: accept when req_valid && req_ready. Latch rs, rnw, last and wdata. Next state is SETUP.
- SETUP, SETUP_CYC cycles:
  - bus_cs=0 and bus_rs=latched rs.
  - Write: bus_dout=wdata, bus_doe=1. Read: bus_doe=0.
  - Strobes stay high.
- STROBE, PULSE_CYC cycles:
  - bus_wr=0 for a write, or bus_rd=0 for a read.
  - For a read, bus_din is captured into rsp_rdata on the clk edge that ends the last STROBE cycle.
- HOLD, HOLD_CYC cycles:
  - Strobe high; CS, RS and dout unchanged.
  - For a read, rsp_valid=1 for exactly the first HOLD cycle.
- HOLD exit:
  - bus_doe=0.
  - If last=1: bus_cs=1. If last=0: bus_cs stays 0 through IDLE so a burst keeps CS asserted.
  - bus_rs keeps its value in IDLE.
  - State returns to IDLE.
- Throughput: one transfer per 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (8 at defaults) when req_valid is held continuously.
- Only one of bus_wr/bus_rd is ever low. Neither is low while bus_cs=1.
- bus_doe is never 1 during a read cycle.
- Requests presented while busy are not accepted. req_* are only sampled in the IDLE handshake cycle; later changes have no effect.
- A burst may mix command and data transfers with CS held low. RS changes only at SETUP entry, never while a strobe is low.

Test Plan:
- Reset check: hold RST=1 for 3 cycles, then release -> bus_cs=1, bus_wr=1, bus_rd=1, bus_rs=1, bus_doe=0, rsp_valid=0, req_ready=1.
- Register write pair: request rs=0, wdata=0x0001, last=0, then rs=1, wdata=0x0002, last=1 -> two WR-low pulses, each 3 cycles long and preceded by 2 setup cycles. bus_cs stays 0 across both. bus_rs=0 on the first pulse and 1 on the second. bus_cs returns to 1 after the second HOLD.
- Read: rs=1, rnw=1, last=1, bench drives bus_din=0xA5C3 during STROBE -> bus_rd low for 3 cycles, bus_wr stays 1, bus_doe=0 throughout. rsp_valid pulses once with rsp_rdata=0xA5C3.
- Pixel stream: req_valid held continuously with data 0x001F, 0x0020, 0x0021, last on the third -> WR falling edges exactly 8 cycles apart, bus_dout matches each word while WR is low, no CS glitch between words.
- Reset mid-operation: assert RST in the second STROBE cycle of a read -> next edge gives bus_rd=1, bus_cs=1, bus_doe=0, no rsp_valid. The next request completes normally.
- Backpressure: change req_wdata from 0x1111 to 0x2222 while busy -> the bus carries 0x1111 only, and exactly one transfer is accepted per handshake.
